// File: rtl/fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx_if
//   Read-port bundle between the 80x8 single-clock FIFO and its serial
//   consumer (fifo_uart_tx).
//
//   Signals
//     fifo_rd     one-cycle pop strobe, driven by the consumer
//     fifo_empty  FIFO empty flag, driven by the FIFO
//     fifo_dout   registered FIFO read data, driven by the FIFO
//
//   Modports
//     master  consumer side (the transmitter): drives fifo_rd
//     slave   FIFO side: drives fifo_empty and fifo_dout
// ---------------------------------------------------------------------------
interface fifo_uart_tx_if;
    logic       fifo_rd;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    modport master (
        output fifo_rd,
        input  fifo_empty,
        input  fifo_dout
    );

    modport slave (
        input  fifo_rd,
        output fifo_empty,
        output fifo_dout
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//   FIFO-draining serial transmitter. Whenever it is enabled and the FIFO
//   is non-empty it pops one byte, waits for the registered FIFO read data,
//   and sends the byte as an asynchronous UART frame: one start bit, eight
//   data bits LSB first, an optional parity bit and one or two stop bits.
//
//   Parameters
//     CLKS_PER_BIT  clk cycles per serial bit (4..65535)
//     CNT_W         baud counter width, must hold CLKS_PER_BIT-1
//     RD_LAT        cycles from the fifo_rd cycle to valid fifo_dout (>= 1)
//     PARITY_EN     1 inserts a parity bit after D7
//     PARITY_ODD    0 even parity, 1 odd parity
//     STOP_BITS     number of stop bits, 1 or 2
//
//   Ports
//     clk         system clock, rising edge
//     rst         synchronous reset, active-high
//     enable      1 allows new frames; 0 finishes the current frame then idles
//     fifo        FIFO read port (master modport: fifo_rd out,
//                 fifo_empty / fifo_dout in)
//     tx_serial   serial line, idle high
//     tx_busy     high from the pop cycle through the last stop cycle
//     frame_done  one-cycle pulse in the last cycle of the final stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16,
    parameter int RD_LAT       = 2,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx_serial,
    output logic                  tx_busy,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic             ODD_SEL   = (PARITY_ODD != 0);
    localparam logic             PAR_ON    = (PARITY_EN != 0);

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             parity_bit;

    // Whole transmitter in one registered FSM. Every output is a flop that
    // is loaded on the edge entering the state it belongs to, so the line
    // value, the pop strobe and the busy flag all line up with the state
    // without any combinational path from inputs.
    //
    // baud_cnt is shared: it times RD_LAT in WAIT and each serial bit in
    // START/DATA/PARITY/STOP, and is cleared on every state or bit change.
    // bit_idx counts data bits in DATA and stop bits in STOP.
    //
    // The shift register drops its LSB after every data bit, so the next
    // line value is always shift_reg[1] at a data-bit boundary. Parity is
    // computed once, from the byte as it is latched.
    //
    // frame_done is loaded one cycle before the final stop cycle so that the
    // registered pulse lands exactly in that last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            parity_bit   <= 1'b0;
            fifo.fifo_rd <= 1'b0;
            tx_serial    <= 1'b1;
            tx_busy      <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            fifo.fifo_rd <= 1'b0;
            frame_done   <= 1'b0;

            case (state)
                S_IDLE: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    baud_cnt  <= '0;
                    bit_idx   <= '0;
                    // fifo_empty is only trusted here; IDLE is always at
                    // least two cycles after the previous pop.
                    if (enable && !fifo.fifo_empty) begin
                        state        <= S_POP;
                        fifo.fifo_rd <= 1'b1;
                        tx_busy      <= 1'b1;
                    end
                end

                S_POP: begin
                    state    <= S_WAIT;
                    baud_cnt <= '0;
                end

                S_WAIT: begin
                    if (baud_cnt == WAIT_LAST) begin
                        shift_reg  <= fifo.fifo_dout;
                        parity_bit <= (^fifo.fifo_dout) ^ ODD_SEL;
                        state      <= S_START;
                        tx_serial  <= 1'b0;
                        baud_cnt   <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_START: begin
                    if (baud_cnt == BIT_LAST) begin
                        state     <= S_DATA;
                        tx_serial <= shift_reg[0];
                        bit_idx   <= '0;
                        baud_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PAR_ON) begin
                                state     <= S_PARITY;
                                tx_serial <= parity_bit;
                            end else begin
                                state     <= S_STOP;
                                tx_serial <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_serial <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (baud_cnt == BIT_LAST) begin
                        state     <= S_STOP;
                        tx_serial <= 1'b1;
                        bit_idx   <= '0;
                        baud_cnt  <= '0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    tx_serial <= 1'b1;
                    if (bit_idx == STOP_LAST && baud_cnt == DONE_CNT) begin
                        frame_done <= 1'b1;
                    end
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            state   <= S_IDLE;
                            bit_idx <= '0;
                            tx_busy <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Self-checking bench for fifo_uart_tx. Three instances:
//     A  defaults (8N1, 16 clocks/bit, RD_LAT 2) fed by a small FIFO model
//        with a two-cycle registered read path
//     B  even parity, two stop bits
//     C  odd parity, one stop bit
//   Frames are compared against hand-computed line patterns held in a
//   vector table; reset, enable drop and mid-frame reset are hand sequences.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;

    always #5 clk = ~clk;

    // ---------------- instance A with FIFO model ----------------
    fifo_uart_tx_if if_a();
    logic       tx_serial_a, tx_busy_a, frame_done_a;
    logic [7:0] mem_a [0:15];
    int         wr_cnt_a = 0;
    int         rd_ptr_a = 0;
    logic [7:0] stage_a = 8'hC3;
    logic [7:0] dout_a  = 8'hC3;
    int         rd_count_a = 0;
    int         done_count_a = 0;

    assign if_a.fifo_empty = (rd_ptr_a >= wr_cnt_a);
    assign if_a.fifo_dout  = dout_a;

    // Two-stage registered read path: data popped in cycle P is on
    // fifo_dout from cycle P+2.
    always @(posedge clk) begin
        if (if_a.fifo_rd === 1'b1) begin
            rd_ptr_a   <= rd_ptr_a + 1;
            stage_a    <= mem_a[rd_ptr_a];
            rd_count_a <= rd_count_a + 1;
        end
        dout_a <= stage_a;
        if (frame_done_a === 1'b1) done_count_a <= done_count_a + 1;
    end

    fifo_uart_tx dut_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo       (if_a.master),
        .tx_serial  (tx_serial_a),
        .tx_busy    (tx_busy_a),
        .frame_done (frame_done_a)
    );

    // ---------------- instances B and C (parity) ----------------
    fifo_uart_tx_if if_b();
    fifo_uart_tx_if if_c();
    logic tx_serial_b, tx_busy_b, frame_done_b;
    logic tx_serial_c, tx_busy_c, frame_done_c;
    int   req_b = 0, pops_b = 0;
    int   req_c = 0, pops_c = 0;

    assign if_b.fifo_empty = (pops_b >= req_b);
    assign if_b.fifo_dout  = 8'h07;
    assign if_c.fifo_empty = (pops_c >= req_c);
    assign if_c.fifo_dout  = 8'h07;

    always @(posedge clk) begin
        if (if_b.fifo_rd === 1'b1) pops_b <= pops_b + 1;
        if (if_c.fifo_rd === 1'b1) pops_c <= pops_c + 1;
    end

    fifo_uart_tx #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo       (if_b.master),
        .tx_serial  (tx_serial_b),
        .tx_busy    (tx_busy_b),
        .frame_done (frame_done_b)
    );

    fifo_uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_c (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo       (if_c.master),
        .tx_serial  (tx_serial_c),
        .tx_busy    (tx_busy_c),
        .frame_done (frame_done_c)
    );

    // Observation mux so one capture task serves all three instances.
    int   sel = 0;
    logic obs_serial, obs_busy, obs_done;

    always_comb begin
        obs_serial = tx_serial_a;
        obs_busy   = tx_busy_a;
        obs_done   = frame_done_a;
        case (sel)
            1: begin
                obs_serial = tx_serial_b;
                obs_busy   = tx_busy_b;
                obs_done   = frame_done_b;
            end
            2: begin
                obs_serial = tx_serial_c;
                obs_busy   = tx_busy_c;
                obs_done   = frame_done_c;
            end
            default: ;
        endcase
    end

    // ---------------- checking infrastructure ----------------
    int checks_total  = 0;
    int checks_passed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Waits (bounded) for a start bit, then samples every cycle of nbits
    // slots. intact drops if a slot is not constant for 16 cycles, busy is
    // not high, or frame_done is high anywhere but the very last cycle.
    // When drop_slot matches, enable is lowered at the start of that slot.
    task automatic captureFrame(input int nbits, input int drop_slot,
                                output logic [11:0] bits, output logic intact);
        int k;
        k = 0;
        bits = '0;
        intact = 1'b1;
        while (obs_serial !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        checkOutput("start_seen", 32'(k < 400), 32'd1);
        for (int b = 0; b < nbits; b++) begin
            if (b == drop_slot) enable = 1'b0;
            bits[b] = obs_serial;
            for (int c = 0; c < 16; c++) begin
                if (obs_serial !== bits[b]) intact = 1'b0;
                if (obs_busy !== 1'b1) intact = 1'b0;
                if (obs_done !== ((b == nbits - 1) && (c == 15))) intact = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        int          dut_sel;
        int          nbits;
        logic [11:0] exp_bits;
        int          exp_gap;
    } vec_t;

    vec_t vecs [6];

    task automatic applyStimulus(input vec_t v);
        sel = v.dut_sel;
        if (v.dut_sel == 1) req_b = req_b + 1;
        if (v.dut_sel == 2) req_c = req_c + 1;
    endtask

    // Watchdog: a hung FSM must still end the run with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [11:0] bits;
        logic        intact;
        int          gap;
        int          rd_snap;
        logic        quiet;
        int          k;

        // Line patterns, slot 0 = start bit, written out by hand.
        // A5 -> 0,1,0,1,0,0,1,0,1,1 ; 00 -> 0,0..0,1 ; FF -> 0,1..1,1
        // 55 -> 0,1,0,1,0,1,0,1,0,1 ; 07 even par -> parity 1, 2 stops
        // 07 odd par -> parity 0, 1 stop
        vecs[0] = '{0, 10, 12'h34A, 4};
        vecs[1] = '{0, 10, 12'h200, 4};
        vecs[2] = '{0, 10, 12'h3FE, 4};
        vecs[3] = '{0, 10, 12'h2AA, -1};
        vecs[4] = '{1, 12, 12'hE0E, -1};
        vecs[5] = '{2, 11, 12'h40E, -1};

        mem_a[0] = 8'hA5;
        mem_a[1] = 8'h00;
        mem_a[2] = 8'hFF;
        mem_a[3] = 8'h55;
        for (int i = 4; i < 16; i++) mem_a[i] = 8'h00;
        wr_cnt_a = 4;

        // Reset held three cycles with data waiting and enable high.
        rst = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("rst_tx_serial", 32'(tx_serial_a), 32'd1);
            checkOutput("rst_fifo_rd",   32'(if_a.fifo_rd), 32'd0);
            checkOutput("rst_tx_busy",   32'(tx_busy_a), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first_pop_rd",   32'(if_a.fifo_rd), 32'd1);
        checkOutput("first_pop_busy", 32'(tx_busy_a), 32'd1);
        @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            captureFrame(vecs[i].nbits, -1, bits, intact);
            checkOutput($sformatf("frame_bits[%0d]", i), 32'(bits), 32'(vecs[i].exp_bits));
            checkOutput($sformatf("frame_intact[%0d]", i), 32'(intact), 32'd1);
            if (vecs[i].exp_gap >= 0) begin
                gap = 0;
                while (obs_serial === 1'b1 && gap < 100) begin
                    gap++;
                    @(negedge clk);
                end
                checkOutput($sformatf("gap[%0d]", i), 32'(gap), 32'(vecs[i].exp_gap));
            end
        end
        sel = 0;
        checkOutput("pop_count_a",  32'(rd_count_a), 32'd4);
        checkOutput("done_count_a", 32'(done_count_a), 32'd4);

        // enable drops during data bit 3: frame finishes, no further pops.
        mem_a[4] = 8'h3C;
        mem_a[5] = 8'h81;
        wr_cnt_a = 6;
        captureFrame(10, 4, bits, intact);
        checkOutput("en_drop_bits",   32'(bits), 32'h278);
        checkOutput("en_drop_intact", 32'(intact), 32'd1);
        rd_snap = rd_count_a;
        quiet = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (tx_serial_a !== 1'b1 || tx_busy_a !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checkOutput("en_low_no_pop", 32'(rd_count_a - rd_snap), 32'd0);
        checkOutput("en_low_quiet",  32'(quiet), 32'd1);
        enable = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reenable_pop", 32'(if_a.fifo_rd), 32'd1);

        // Reset during data bit 4 of the 0x81 frame; 0x81 is lost.
        mem_a[6] = 8'h5A;
        wr_cnt_a = 7;
        @(negedge clk);
        k = 0;
        while (tx_serial_a !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        checkOutput("rst_frame_start", 32'(k < 400), 32'd1);
        repeat (5 * 16 + 3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_tx_serial", 32'(tx_serial_a), 32'd1);
        checkOutput("midrst_tx_busy",   32'(tx_busy_a), 32'd0);
        checkOutput("midrst_fifo_rd",   32'(if_a.fifo_rd), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_fresh_pop", 32'(if_a.fifo_rd), 32'd1);
        @(negedge clk);
        captureFrame(10, -1, bits, intact);
        checkOutput("post_rst_bits",   32'(bits), 32'h2B4);
        checkOutput("post_rst_intact", 32'(intact), 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("final_pop_count",  32'(rd_count_a), 32'd7);
        checkOutput("final_done_count", 32'(done_count_a), 32'd6);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
